// File: rtl/pedestrian_request.sv
// Pedestrian push-button front end: synchronise/debounce a button, hold a crossing
// request, grant a walk at the start of the next red phase, then lock out new presses.
module pedestrian_request #(
    parameter int unsigned DEBOUNCE  = 4,
    parameter int unsigned WALK_CYC  = 2,
    parameter int unsigned CLEAR_CYC = 1,
    parameter int unsigned LOCK_CYC  = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Button,
    input  logic Red,
    input  logic Green,
    input  logic Yellow,
    output logic Request,
    output logic Waiting,
    output logic Walk,
    output logic DontWalk
);

    localparam logic [7:0] DEB_C   = 8'(DEBOUNCE);
    localparam logic [7:0] WALK_C  = 8'(WALK_CYC);
    localparam logic [7:0] CLEAR_C = 8'(CLEAR_CYC);
    localparam logic [7:0] LOCK_C  = 8'(LOCK_CYC);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PENDING = 3'd1,
        ST_WALK    = 3'd2,
        ST_CLEAR   = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    logic       s1_q, s2_q;
    logic       db_q, db_d;
    logic       db_prev_q;
    logic [7:0] dcnt_q, dcnt_d;
    logic [7:0] dcnt_inc;
    logic       red_q;
    logic       press, red_rise, red_fall;

    state_t     state_q, state_d;
    logic [7:0] pcnt_q, pcnt_d;

    // The light controller's yellow lamp carries no information this block needs.
    logic unused_yellow;
    assign unused_yellow = Yellow;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            dcnt_q    <= 8'd0;
            red_q     <= 1'b0;
        end else begin
            s1_q      <= Button;
            s2_q      <= s1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            dcnt_q    <= dcnt_d;
            red_q     <= Red;
        end
    end

    assign dcnt_inc = dcnt_q + 8'd1;

    // Any cycle where the synchronised level agrees with db restarts the count.
    always_comb begin
        db_d   = db_q;
        dcnt_d = 8'd0;
        if (s2_q != db_q) begin
            if (dcnt_inc == DEB_C) begin
                db_d   = s2_q;
                dcnt_d = 8'd0;
            end else begin
                dcnt_d = dcnt_inc;
            end
        end
    end

    assign press    = db_q & ~db_prev_q;
    assign red_rise = Red & ~red_q;
    assign red_fall = ~Red & red_q;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            pcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (press) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                if (red_rise) begin
                    state_d = ST_WALK;
                    pcnt_d  = WALK_C;
                end
            end
            ST_WALK: begin
                if (red_fall) begin
                    state_d = ST_LOCKOUT;
                    pcnt_d  = LOCK_C;
                end else if (pcnt_q == 8'd1) begin
                    state_d = ST_CLEAR;
                    pcnt_d  = CLEAR_C;
                end else begin
                    pcnt_d  = pcnt_q - 8'd1;
                end
            end
            ST_CLEAR: begin
                if (red_fall || pcnt_q == 8'd1) begin
                    state_d = ST_LOCKOUT;
                    pcnt_d  = LOCK_C;
                end else begin
                    pcnt_d  = pcnt_q - 8'd1;
                end
            end
            ST_LOCKOUT: begin
                if (pcnt_q == 8'd1) state_d = ST_IDLE;
                else                pcnt_d  = pcnt_q - 8'd1;
            end
            default: begin
                state_d = ST_IDLE;
                pcnt_d  = 8'd0;
            end
        endcase
    end

    // Walk is gated by the live Red input so it can never lead or trail red.
    always_comb begin
        Walk     = (state_q == ST_WALK) & Red;
        DontWalk = ~Walk;
        Waiting  = (state_q == ST_PENDING);
        Request  = (state_q == ST_PENDING) & Green;
    end

endmodule

// File: tb/tb_pedestrian_request.sv
// Randomised light/button stimulus checked every cycle against a phase-level model.
module tb_pedestrian_request;

    localparam int DEB   = 4;
    localparam int WALKC = 2;
    localparam int CLRC  = 1;
    localparam int LOCKC = 8;

    logic Clock = 1'b0;
    logic Reset, Button, Red, Green, Yellow;
    logic Request, Waiting, Walk, DontWalk;

    always #5 Clock = ~Clock;

    pedestrian_request #(
        .DEBOUNCE(DEB), .WALK_CYC(WALKC), .CLEAR_CYC(CLRC), .LOCK_CYC(LOCKC)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Button(Button),
        .Red(Red), .Green(Green), .Yellow(Yellow),
        .Request(Request), .Waiting(Waiting), .Walk(Walk), .DontWalk(DontWalk)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 0;

    // Reference model: raw button history, debounced level, and remaining
    // cycles of each service interval (zero = interval not active).
    int m_s1, m_s2, m_db, m_dbp, m_run, m_redp;
    int m_pend, m_walk_left, m_clear_left, m_lock_left;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_db = 0; m_dbp = 0; m_run = 0; m_redp = 0;
        m_pend = 0; m_walk_left = 0; m_clear_left = 0; m_lock_left = 0;
    endtask

    task automatic model_step();
        int pressed, rr, rf;
        if (!Reset) begin
            model_reset();
            return;
        end
        pressed = (m_db == 1 && m_dbp == 0);
        rr      = (Red == 1'b1 && m_redp == 0);
        rf      = (Red == 1'b0 && m_redp == 1);
        if (m_walk_left > 0) begin
            if (rf)                    begin m_walk_left = 0; m_lock_left = LOCKC; end
            else if (m_walk_left == 1) begin m_walk_left = 0; m_clear_left = CLRC; end
            else m_walk_left--;
        end else if (m_clear_left > 0) begin
            if (rf || m_clear_left == 1) begin m_clear_left = 0; m_lock_left = LOCKC; end
            else m_clear_left--;
        end else if (m_lock_left > 0) begin
            m_lock_left--;
        end else if (m_pend == 1) begin
            if (rr) begin m_pend = 0; m_walk_left = WALKC; end
        end else if (pressed) begin
            m_pend = 1;
        end
        m_dbp = m_db;
        if (m_s2 != m_db) begin
            m_run++;
            if (m_run == DEB) begin m_db = m_s2; m_run = 0; end
        end else begin
            m_run = 0;
        end
        m_s2   = m_s1;
        m_s1   = int'(Button);
        m_redp = int'(Red);
    endtask

    task automatic tick(input logic b, input logic r, input logic g, input logic y, input logic rst);
        logic e_walk;
        Button = b; Red = r; Green = g; Yellow = y; Reset = rst;
        @(negedge Clock);
        if (chk_en) begin
            e_walk = (m_walk_left > 0) && (Red == 1'b1);
            check_eq("walk",     32'(Walk),     32'(e_walk));
            check_eq("dontwalk", 32'(DontWalk), 32'(!e_walk));
            check_eq("waiting",  32'(Waiting),  32'(m_pend == 1));
            check_eq("request",  32'(Request),  32'(m_pend == 1 && Green == 1'b1));
        end
        @(posedge Clock);
        model_step();
        #1;
    endtask

    initial begin
        int lat;
        int lt, lt_left, btn_left;
        logic btn, r, g, y, rst;

        Button = 0; Red = 0; Green = 0; Yellow = 0; Reset = 0;
        model_reset();
        repeat (3) tick(0, 0, 0, 0, 0);
        chk_en = 1;
        tick(0, 0, 1, 0, 0);
        check_eq("reset_dontwalk", 32'(DontWalk), 32'd1);

        // Short glitches must not register as a press.
        repeat (3) begin
            repeat (3) tick(1, 0, 1, 0, 1);
            repeat (6) tick(0, 0, 1, 0, 1);
        end
        check_eq("glitch_waiting", 32'(Waiting), 32'd0);

        lat = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1, 0, 1, 0, 1);
            if (Waiting === 1'b1 && lat < 0) lat = i;
        end
        check_eq("press_latency", 32'(lat), 32'(DEB + 2));
        check_eq("request_green", 32'(Request), 32'd1);

        lt = 0; lt_left = 5; btn_left = 4; btn = 0;
        for (int c = 0; c < 3000; c++) begin
            if (lt_left == 0) begin
                lt = (lt + 1) % 3;
                case (lt)
                    0:       lt_left = $urandom_range(3, 20);
                    1:       lt_left = $urandom_range(1, 3);
                    default: lt_left = $urandom_range(1, 14);
                endcase
            end
            lt_left--;
            if (btn_left == 0) begin
                btn = ~btn;
                btn_left = $urandom_range(1, 12);
            end
            btn_left--;
            g = (lt == 0);
            y = (lt == 1);
            r = (lt == 2);
            if ($urandom_range(0, 31) == 0) g = ~g;
            rst = ($urandom_range(0, 499) != 0);
            tick(btn, r, g, y, rst);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pedestrian_request.md
# pedestrian_request

Pedestrian push-button front end that sits upstream of the traffic-light controller. It synchronises and debounces a raw button and holds a pending crossing request. While the light is green it raises `Request` so the controller can end green early. It grants a walk interval at the start of the next red phase, then enforces a lockout before accepting another press. It reads back the controller's Red/Green/Yellow outputs to track the phase and to gate `Walk` for safety.

## Interface
Parameters:
- `DEBOUNCE`, 4: consecutive cycles the synchronised button must differ from the debounced value before the debounced value changes (1..255).
- `WALK_CYC`, 2: cycles `Walk` is asserted per grant (1..255).
- `CLEAR_CYC`, 1: clearance cycles after walk, with `Walk`=0 and no new grant (1..255).
- `LOCK_CYC`, 8: cycles during which presses are discarded after service (1..255).

Ports:
- `Clock`  in  1  single clock; all state updates on posedge.
- `Reset`  in  1  synchronous, active-low reset.
- `Button`  in  1  raw, asynchronous push-button level; 1 = pressed.
- `Red`, `Green`, `Yellow`  in  1 each  current light outputs from the traffic controller.
- `Request`  out  1  asks the controller to terminate green early.
- `Waiting`  out  1  "request accepted" indicator lamp.
- `Walk`  out  1  walk signal.
- `DontWalk`  out  1  always equal to ~`Walk`.

## Operation
- Input path: two-flop synchroniser `Button`→s1→s2.
  - 8-bit debounce counter counts edges where s2≠db and clears on any edge where s2==db.
  - db takes s2 on the edge where the counter reaches `DEBOUNCE`; the counter clears on that edge.
  - press = db & ~db_q, a one-cycle event.
- `Red` is registered as red_q. red_rise = `Red` & ~red_q; red_fall = ~`Red` & red_q.
- FSM states: IDLE, PENDING, WALK, CLEAR, LOCKOUT. One 8-bit phase counter is shared by WALK, CLEAR and LOCKOUT.
  - IDLE: press → PENDING. Otherwise stay.
  - PENDING: red_rise → WALK, loading counter = `WALK_CYC`. Presses are ignored.
  - WALK: red_fall → LOCKOUT (load `LOCK_CYC`). Else counter==1 → CLEAR (load `CLEAR_CYC`). Else decrement.
  - CLEAR: red_fall or counter==1 → LOCKOUT (load `LOCK_CYC`). Else decrement.
  - LOCKOUT: counter==1 → IDLE. Else decrement. Presses are discarded, with no queuing.
- Outputs (combinational from state and inputs):
  - `Walk` = (state==WALK) & `Red`. It is never 1 while `Red`=0, even for one cycle.
  - `Waiting` = (state==PENDING).
  - `Request` = (state==PENDING) & `Green`.
- Non-one-hot light inputs: no special handling. Each output uses only the bit named in its equation above.

## Timing
- Reset (`Reset`=0 at an edge):
  - Outputs: `Walk`=0, `DontWalk`=1, `Request`=0, `Waiting`=0.
  - Internal: state=IDLE; s1, s2, db, db_q, red_q and all counters = 0.
  - Reset mid-operation abandons any pending or active grant.
- Press latency: with `Button` going high before edge k and held, `Waiting` rises after edge k+2+`DEBOUNCE` (k+6 at defaults).
- Glitches: a high pulse shorter than `DEBOUNCE` cycles at s2 produces no press.
- Release: release is debounced identically. A new press requires db to return to 0 first.
- Grant: `Walk` rises the cycle after the edge that samples red_rise. It stays high `WALK_CYC` cycles, or until `Red` falls.
- After a full walk: `LOCK_CYC` cycles of LOCKOUT precede IDLE.
- Press while `Red` already high: the grant waits for the next red_rise, so a partial red phase is never granted.
- press and red_rise in the same cycle in IDLE: go to PENDING only. No grant until the following red_rise.
- `Request` follows `Green` combinationally while PENDING. It drops in the same cycle `Green` drops.

## Test plan
- Reset mid-walk: in WALK, drive `Reset`=0 for one edge → next cycle `Walk`=0, `DontWalk`=1, `Waiting`=0, `Request`=0. A subsequent red_rise with no press gives no `Walk`.
- Debounce: `Button` pulses of 3 cycles → `Waiting` stays 0. A 6-cycle hold → `Waiting`=1 exactly 6 cycles after the first sampling edge.
- Green shortening: press during green → `Request`=1 while `Green`=1. When `Red` rises, `Walk`=1 for 2 cycles, `Walk`=0 for 1 clear cycle, then 8 lockout cycles, then IDLE.
- Early red end: `Red` falls after 1 walk cycle → `Walk`=0 in that same cycle. State goes to LOCKOUT at the next edge.
- Lockout discard: press during LOCKOUT → no `Waiting`, no grant at the next red_rise. The same press repeated in IDLE → `Waiting`=1.
- Press during red: press with `Red`=1 already high → `Walk` stays 0 for the rest of that red phase. `Walk` asserts one cycle after the next red_rise.
